// File: rtl/jpeg_axis_block_buffer.sv
// jpeg_axis_block_buffer: ping-pong 8x8 pixel block buffer that drains planar, optionally level-shifted channel samples
module jpeg_axis_block_buffer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int INPUT_WIDTH = 8,
  parameter int NUM_CH = 3,
  parameter int DATA_DEPTH = 8,
  parameter int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH,
  parameter int DATA_WIDTH = 15
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_reset,
  input  logic                                  level_shift_en,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic                                  err_tlast,
  output logic [15:0]                           blocks_out
);
  localparam int IDX_W = $clog2(PIXEL_COUNT);
  localparam int FW = $clog2(PIXEL_COUNT + 1);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(2 * NUM_CH * PIXEL_COUNT);
  localparam logic [DATA_WIDTH-1:0] OFS = DATA_WIDTH'(1) << (INPUT_WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RELEASE} state_t;
  logic [INPUT_WIDTH-1:0] mem [2*NUM_CH*PIXEL_COUNT];
  logic [FW-1:0] fill [2];
  logic [1:0] full, full_n;
  logic wr_bank, rd_bank, shift, rd_done, start, rel, load, hs_in, last_in, close, last_pos;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CW-1:0] rd_ch;
  logic [AW-1:0] rd_addr;
  logic [INPUT_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] smp;
  state_t state, state_n;
  logic unused_in;
  assign unused_in = ^{s00_axis_tstrb, s00_axis_tdata};
  assign hs_in = s00_axis_tvalid && s00_axis_tready;
  assign last_in = wr_idx == IDX_W'(PIXEL_COUNT - 1);
  assign close = hs_in && (s00_axis_tlast || last_in);
  assign full_n = (full | ({1'b0, close} << wr_bank)) & ~({1'b0, rel} << rd_bank);
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      full <= '0;
      fill[0] <= '0;
      fill[1] <= '0;
      wr_bank <= 1'b0;
      wr_idx <= '0;
      s00_axis_tready <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      full <= full_n;
      s00_axis_tready <= !full_n[wr_bank ^ close];
      err_tlast <= hs_in && (s00_axis_tlast != last_in);
      if (hs_in) wr_idx <= close ? '0 : wr_idx + IDX_W'(1);
      if (close) begin
        fill[wr_bank] <= FW'(wr_idx) + FW'(1);
        wr_bank <= !wr_bank;
      end
    end
  end
  always_ff @(posedge axis_aclk) begin
    if (hs_in)
      for (int c = 0; c < NUM_CH; c++)
        mem[AW'((32'(wr_bank) * NUM_CH + c) * PIXEL_COUNT + 32'(wr_idx))] <= s00_axis_tdata[c*INPUT_WIDTH +: INPUT_WIDTH];
  end
  always_ff @(posedge axis_aclk) state <= axis_reset ? S_IDLE : state_n;
  always_comb begin
    state_n = state == S_IDLE   ? (full[rd_bank] ? S_STREAM : S_IDLE) :
              state == S_STREAM ? (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast ? S_RELEASE : S_STREAM) :
                                  S_IDLE;
  end
  always_comb begin
    start = state == S_IDLE && full[rd_bank];
    rel = state == S_RELEASE;
    load = state == S_STREAM && !rd_done && (!m00_axis_tvalid || m00_axis_tready);
  end
  assign last_pos = rd_ch == CW'(NUM_CH - 1) && rd_idx == IDX_W'(PIXEL_COUNT - 1);
  assign rd_addr = AW'((32'(rd_bank) * NUM_CH + 32'(rd_ch)) * PIXEL_COUNT + 32'(rd_idx));
  assign raw = FW'(rd_idx) < fill[rd_bank] ? mem[rd_addr] : '0;
  assign smp = DATA_WIDTH'(raw) - (shift ? OFS : '0);
  assign m00_axis_tstrb = {(C_M00_AXIS_TDATA_WIDTH/8){m00_axis_tvalid}};
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      rd_bank <= 1'b0;
      rd_idx <= '0;
      rd_ch <= '0;
      rd_done <= 1'b0;
      shift <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata <= '0;
      m00_axis_tlast <= 1'b0;
      blocks_out <= '0;
    end else begin
      if (start) begin
        rd_idx <= '0;
        rd_ch <= '0;
        rd_done <= 1'b0;
        shift <= level_shift_en;
      end
      if (rel) begin
        rd_bank <= !rd_bank;
        blocks_out <= blocks_out + 16'd1;
      end
      if (load) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tdata <= {{(C_M00_AXIS_TDATA_WIDTH-DATA_WIDTH){smp[DATA_WIDTH-1]}}, smp};
        m00_axis_tlast <= last_pos;
        rd_idx <= rd_idx == IDX_W'(PIXEL_COUNT - 1) ? '0 : rd_idx + IDX_W'(1);
        rd_ch <= rd_idx == IDX_W'(PIXEL_COUNT - 1) && !last_pos ? rd_ch + CW'(1) : rd_ch;
        rd_done <= last_pos;
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
        m00_axis_tlast <= 1'b0;
      end
    end
  end
endmodule
